fetch_if_id_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of hazard detection.

---
 rtl/fetch_if_id_stage.sv | 195 +++++++++++++++++++
 tb/tb_fetch_if_id_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and next-PC selection, captures fetched words into IF/ID,
// counts stall/flush cycles and raises a sticky watchdog flag when a
// stall persists longer than STALL_LIMIT consecutive cycles.
module fetch_if_id_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 16,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall_PC,
  input  logic        Stall_ID,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  input  logic [31:0] IM_Instruction,
  output logic [31:0] IM_Address,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count,
  output logic        Stall_Timeout
);

  // Watchdog states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HUNG  = 2'd2
  } wd_state_t;

  // Architectural registers
  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_valid;
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;
  logic        r_stall_timeout;
  wd_state_t   r_state;
  logic [15:0] r_run_len;

  // Combinational helpers
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_target;
  logic        w_stall_event;
  logic [15:0] w_run_len_inc;
  logic        w_over_limit;
  wd_state_t   w_state_next;
  logic [15:0] w_run_len_next;
  logic        w_set_timeout;

  // Sequential PC increment wraps naturally at 2^32.
  assign w_pc_plus4        = r_pc + 32'd4;
  // Targets are word aligned; the two low bits are simply discarded.
  assign w_redirect_target = Redirect_PC & ~32'd3;
  // A stall cycle only counts when no redirect overrides it.
  assign w_stall_event     = Stall_PC & ~Redirect;
  // Run length saturates so a very long stall cannot wrap back below the limit.
  assign w_run_len_inc     = (r_run_len == 16'hFFFF) ? r_run_len : (r_run_len + 16'd1);
  assign w_over_limit      = (32'(w_run_len_inc) > STALL_LIMIT);

  // PC register: redirect beats stall, otherwise advance by one word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc <= RESET_PC;
    end else if (Redirect) begin
      r_pc <= w_redirect_target;
    end else if (!Stall_PC) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register: flush on redirect, hold on ID stall, bubble on PC-only stall.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_id_instr    <= NOP_WORD;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
    end else if (Redirect) begin
      r_id_instr    <= NOP_WORD;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
    end else if (Stall_ID) begin
      r_id_instr    <= r_id_instr;
      r_id_pc_plus4 <= r_id_pc_plus4;
      r_id_valid    <= r_id_valid;
    end else if (Stall_PC) begin
      // The word at the held PC is fetched again next cycle, so drop this copy.
      r_id_instr    <= NOP_WORD;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
    end else begin
      r_id_instr    <= IM_Instruction;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_stall_event && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (Redirect && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  // Watchdog state register, run-length counter and sticky timeout flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state         <= ST_RUN;
      r_run_len       <= 16'd0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_run_len <= w_run_len_next;
      if (w_set_timeout) begin
        r_stall_timeout <= 1'b1;
      end
    end
  end

  // Watchdog next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_stall_event) begin
          w_state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!w_stall_event) begin
          w_state_next = ST_RUN;
        end else if (w_over_limit) begin
          w_state_next = ST_HUNG;
        end
      end
      ST_HUNG: begin
        if (!w_stall_event) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Watchdog outputs: run-length update and timeout set pulse.
  always_comb begin
    w_run_len_next = r_run_len;
    w_set_timeout  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_stall_event) begin
          w_run_len_next = 16'd1;
        end
      end
      ST_STALL: begin
        if (!w_stall_event) begin
          w_run_len_next = 16'd0;
        end else begin
          w_run_len_next = w_run_len_inc;
          w_set_timeout  = w_over_limit;
        end
      end
      ST_HUNG: begin
        if (!w_stall_event) begin
          w_run_len_next = 16'd0;
        end
      end
      default: begin
        w_run_len_next = 16'd0;
      end
    endcase
  end

  assign IM_Address     = r_pc;
  assign ID_Instruction = r_id_instr;
  assign ID_PCPlus4     = r_id_pc_plus4;
  assign ID_Valid       = r_id_valid;
  assign Stall_Count    = r_stall_count;
  assign Flush_Count    = r_flush_count;
  assign Stall_Timeout  = r_stall_timeout;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed stimulus, a spec-level reference model
// checked after every clock, plus hand-computed literal expectations.
module tb_fetch_if_id_stage;

  localparam logic [31:0] P_RESET_PC    = 32'h0000_0000;
  localparam int unsigned P_STALL_LIMIT = 16;
  localparam logic [31:0] P_NOP_WORD    = 32'h0000_0000;

  logic        Clock;
  logic        Reset;
  logic        Stall_PC;
  logic        Stall_ID;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic [31:0] IM_Instruction;
  logic [31:0] IM_Address;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCPlus4;
  logic        ID_Valid;
  logic [31:0] Stall_Count;
  logic [31:0] Flush_Count;
  logic        Stall_Timeout;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;
  logic        m_timeout;
  int          m_streak;

  fetch_if_id_stage #(
    .RESET_PC   (P_RESET_PC),
    .STALL_LIMIT(P_STALL_LIMIT),
    .NOP_WORD   (P_NOP_WORD)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Stall_PC      (Stall_PC),
    .Stall_ID      (Stall_ID),
    .Redirect      (Redirect),
    .Redirect_PC   (Redirect_PC),
    .IM_Instruction(IM_Instruction),
    .IM_Address    (IM_Address),
    .ID_Instruction(ID_Instruction),
    .ID_PCPlus4    (ID_PCPlus4),
    .ID_Valid      (ID_Valid),
    .Stall_Count   (Stall_Count),
    .Flush_Count   (Flush_Count),
    .Stall_Timeout (Stall_Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Instruction memory: each word is tagged with its own address.
  function automatic logic [31:0] im_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  assign IM_Instruction = im_word(IM_Address);

  // One edge of the specification's behaviour, using the inputs as applied.
  task automatic model_step();
    logic [31:0] next_pc;
    if (Reset) begin
      m_pc = P_RESET_PC; m_instr = P_NOP_WORD; m_pc4 = 0; m_valid = 0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_timeout = 0; m_streak = 0;
      return;
    end
    if (Redirect)       next_pc = Redirect_PC & 32'hFFFF_FFFC;
    else if (Stall_PC)  next_pc = m_pc;
    else                next_pc = m_pc + 32'd4;
    if (Redirect || (Stall_PC && !Stall_ID)) begin
      m_instr = P_NOP_WORD; m_pc4 = 0; m_valid = 0;
    end else if (!Stall_ID) begin
      m_instr = im_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
    end
    if (Stall_PC && !Redirect) begin
      if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      m_streak++;
    end else begin
      m_streak = 0;
    end
    if (Redirect && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    if (m_streak > int'(P_STALL_LIMIT)) m_timeout = 1;
    m_pc = next_pc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc_no, act, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_model();
    chk("IM_Address", IM_Address, m_pc);
    chk("ID_Instruction", ID_Instruction, m_instr);
    chk("ID_PCPlus4", ID_PCPlus4, m_pc4);
    chk("ID_Valid", 32'(ID_Valid), 32'(m_valid));
    chk("Stall_Count", Stall_Count, m_stall_cnt);
    chk("Flush_Count", Flush_Count, m_flush_cnt);
    chk("Stall_Timeout", 32'(Stall_Timeout), 32'(m_timeout));
  endtask

  // Apply inputs for one clock, advance the model at the edge, check at the falling edge.
  task automatic cyc(input logic spc, input logic sid, input logic rd,
                     input logic [31:0] rpc, input logic rst);
    Stall_PC = spc; Stall_ID = sid; Redirect = rd; Redirect_PC = rpc; Reset = rst;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    cyc_no++;
    compare_model();
    $display("cycle=%0d rst=%0b spc=%0b sid=%0b rd=%0b rpc=0x%08h -> pc=0x%08h id=0x%08h pc4=0x%08h v=%0b sc=%0d fc=%0d to=%0b",
             cyc_no, rst, spc, sid, rd, rpc, IM_Address, ID_Instruction, ID_PCPlus4,
             ID_Valid, Stall_Count, Flush_Count, Stall_Timeout);
  endtask

  initial begin
    Reset = 1'b1; Stall_PC = 1'b0; Stall_ID = 1'b0; Redirect = 1'b0; Redirect_PC = 32'd0;
    @(negedge Clock);

    // Reset state
    cyc(0, 0, 0, 32'd0, 1);
    chk("lit_reset_pc", IM_Address, 32'h0);
    chk("lit_reset_valid", 32'(ID_Valid), 32'd0);
    chk("lit_reset_stallcnt", Stall_Count, 32'd0);

    // Free run: PC 4, 8, 12, 16
    cyc(0, 0, 0, 32'd0, 0);
    chk("lit_run1_instr", ID_Instruction, 32'hC0DE_0000);
    chk("lit_run1_valid", 32'(ID_Valid), 32'd1);
    cyc(0, 0, 0, 32'd0, 0);
    cyc(0, 0, 0, 32'd0, 0);
    chk("lit_run3_pc", IM_Address, 32'd12);
    chk("lit_run3_pc4", ID_PCPlus4, 32'd12);
    cyc(0, 0, 0, 32'd0, 0);

    // Combined stall for 3 cycles at PC=0x10
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'd0, 0);
    chk("lit_stall_pc", IM_Address, 32'h10);
    chk("lit_stall_pc4", ID_PCPlus4, 32'h10);
    chk("lit_stall_cnt", Stall_Count, 32'd3);
    cyc(0, 0, 0, 32'd0, 0);
    chk("lit_resume_pc", IM_Address, 32'h14);

    // Redirect with simultaneous stall, misaligned target
    cyc(1, 1, 1, 32'h0000_0103, 0);
    chk("lit_redir_pc", IM_Address, 32'h100);
    chk("lit_redir_valid", 32'(ID_Valid), 32'd0);
    chk("lit_redir_flush", Flush_Count, 32'd1);
    chk("lit_redir_stallcnt", Stall_Count, 32'd3);
    cyc(0, 0, 0, 32'd0, 0);
    chk("lit_after_redir_pc4", ID_PCPlus4, 32'h104);

    // PC-only stall: PC holds, IF/ID takes a bubble
    cyc(1, 0, 0, 32'd0, 0);
    chk("lit_bubble_valid", 32'(ID_Valid), 32'd0);
    cyc(0, 0, 0, 32'd0, 0);

    // Watchdog: 16 stall edges stay quiet, the 17th sets the flag
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 32'd0, 0);
    chk("lit_wd16", 32'(Stall_Timeout), 32'd0);
    cyc(1, 1, 0, 32'd0, 0);
    chk("lit_wd17", 32'(Stall_Timeout), 32'd1);
    cyc(1, 1, 0, 32'd0, 0);
    cyc(0, 0, 0, 32'd0, 0);
    chk("lit_wd_sticky", 32'(Stall_Timeout), 32'd1);
    cyc(0, 0, 1, 32'h0000_0200, 0);
    cyc(0, 0, 0, 32'd0, 0);
    chk("lit_wd_sticky2", 32'(Stall_Timeout), 32'd1);

    // Wrap from 0xFFFF_FFFC
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("lit_wrap_pre", IM_Address, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'd0, 0);
    chk("lit_wrap_pc", IM_Address, 32'h0);
    chk("lit_wrap_pc4", ID_PCPlus4, 32'h0);
    chk("lit_wrap_instr", ID_Instruction, 32'h3F21_FFFC);

    // Reset in the middle of a 5-cycle stall (with a redirect on the same edge)
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'd0, 0);
    cyc(1, 1, 1, 32'h0000_0400, 1);
    chk("lit_midreset_pc", IM_Address, P_RESET_PC);
    chk("lit_midreset_sc", Stall_Count, 32'd0);
    chk("lit_midreset_fc", Flush_Count, 32'd0);
    chk("lit_midreset_to", 32'(Stall_Timeout), 32'd0);
    cyc(1, 1, 0, 32'd0, 0);
    // Watchdog restarted from RUN: 16 fresh stall edges must not time out
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 32'd0, 0);
    chk("lit_fsm_restart", 32'(Stall_Timeout), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'd0, 0);
    chk("lit_final_pc", IM_Address, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
